// File: rtl/cpu_defs.sv
// Shared definitions for the boot loader and the CPU/memory top.
// Holds default bus widths, loader FSM states and error codes.
package cpu_defs;

    localparam int DEF_DWIDTH = 16;
    localparam int DEF_AWIDTH = 12;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN_LO  = 3'd1,
        S_DATA_HI = 3'd2,
        S_DATA_LO = 3'd3,
        S_DRAIN   = 3'd4,
        S_START   = 3'd5,
        S_DONE    = 3'd6,
        S_ERR     = 3'd7
    } ld_state_e;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_OVR  = 2'b10;

endpackage

// File: rtl/byte_pack.sv
// Big-endian byte pair assembler feeding a one-word write slot.
// A new word may replace the slot only if it is empty or retiring now.
module byte_pack
    import cpu_defs::*;
#(
    parameter int DWIDTH = DEF_DWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              hi_ld_i,
    input  logic              push_i,
    input  logic              retire_i,
    input  logic [7:0]        byte_i,
    output logic [DWIDTH-1:0] word_o,
    output logic              slot_full_o,
    output logic              overrun_o
);

    logic [7:0]        hi_q;
    logic [DWIDTH-1:0] word_q;
    logic              full_q;

    assign overrun_o   = push_i && full_q && !retire_i;
    assign word_o      = word_q;
    assign slot_full_o = full_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q   <= '0;
            word_q <= '0;
            full_q <= 1'b0;
        end else if (clr_i) begin
            hi_q   <= '0;
            full_q <= 1'b0;
        end else begin
            if (hi_ld_i) begin
                hi_q <= byte_i;
            end
            if (push_i && !overrun_o) begin
                word_q <= {hi_q, byte_i};
                full_q <= 1'b1;
            end else if (retire_i) begin
                full_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: length-prefixed byte stream into memory from address 0,
// then a single CPU start pulse. Owns the memory port while loading.
module prog_loader
    import cpu_defs::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int AWIDTH = DEF_AWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              reload,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_din,
    output logic              mem_we,
    input  logic              mem_ack,
    output logic              cpu_start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [AWIDTH:0]   words_loaded
);

    localparam logic [16:0]   MAX_N = 17'(1) << AWIDTH;
    localparam logic [AWIDTH:0] W1  = (AWIDTH+1)'(1);

    ld_state_e         state_q, state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [AWIDTH:0]   len_q, len_d;
    logic [AWIDTH:0]   cnt_q, cnt_d;
    logic [AWIDTH:0]   wl_q, wl_d;
    logic [1:0]        ecode_q, ecode_d;

    logic [15:0]       n16;
    logic              too_big, last;
    logic              hi_ld, push, retire, clr;
    logic              slot_full, overrun;
    logic [DWIDTH-1:0] word;

    assign n16     = {len_hi_q, rx_data};
    assign too_big = {1'b0, n16} > MAX_N;
    assign last    = (cnt_q + W1) == len_q;
    assign hi_ld   = (state_q == S_DATA_HI) && rx_valid;
    assign push    = (state_q == S_DATA_LO) && rx_valid;
    assign retire  = mem_we && mem_ack;
    assign clr     = reload && (state_q == S_ERR || state_q == S_DONE);

    byte_pack #(
        .DWIDTH(DWIDTH)
    ) u_pack (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (clr),
        .hi_ld_i     (hi_ld),
        .push_i      (push),
        .retire_i    (retire),
        .byte_i      (rx_data),
        .word_o      (word),
        .slot_full_o (slot_full),
        .overrun_o   (overrun)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            len_hi_q <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            wl_q     <= '0;
            ecode_q  <= ERR_NONE;
        end else begin
            state_q  <= state_d;
            len_hi_q <= len_hi_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            wl_q     <= wl_d;
            ecode_q  <= ecode_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        len_hi_d = len_hi_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        ecode_d  = ecode_q;
        wl_d     = retire ? wl_q + W1 : wl_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (rx_valid) begin
                    len_hi_d = rx_data;
                    state_d  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (rx_valid) begin
                    if (too_big) begin
                        ecode_d = ERR_LEN;
                        state_d = S_ERR;
                    end else if (n16 == '0) begin
                        state_d = S_START;
                    end else begin
                        len_d   = n16[AWIDTH:0];
                        state_d = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: begin
                if (rx_valid) begin
                    state_d = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (rx_valid) begin
                    if (overrun) begin
                        ecode_d = ERR_OVR;
                        state_d = S_ERR;
                    end else begin
                        cnt_d   = cnt_q + W1;
                        state_d = last ? S_DRAIN : S_DATA_HI;
                    end
                end
            end
            S_DRAIN: begin
                if (!slot_full) begin
                    state_d = S_START;
                end
            end
            S_START: state_d = S_DONE;
            S_DONE: begin
                if (reload) begin
                    wl_d    = '0;
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                if (reload) begin
                    wl_d    = '0;
                    ecode_d = ERR_NONE;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A faulted load must not touch memory again, even with a word pending.
    assign mem_we       = slot_full && (state_q != S_ERR);
    assign mem_addr     = wl_q[AWIDTH-1:0];
    assign mem_din      = word;
    assign cpu_start    = (state_q == S_START);
    assign done         = (state_q == S_DONE);
    assign err          = (state_q == S_ERR);
    assign busy         = (state_q == S_LEN_LO) || (state_q == S_DATA_HI)
                       || (state_q == S_DATA_LO) || (state_q == S_DRAIN)
                       || (state_q == S_START);
    assign err_code     = ecode_q;
    assign words_loaded = wl_q;

endmodule
